// File: rtl/imem_loader_if.sv
// Boot byte stream and instruction-memory write bus shared by the loader and its environment.
// The loader takes the slave side: it consumes the stream and drives the write port.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_wr_en,
    input  imem_wr_addr,
    input  imem_wr_data
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_wr_en,
    output imem_wr_addr,
    output imem_wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a little-endian framed byte stream (word count, then words),
// writes it into instruction memory and releases the CPU reset when the load completes.
module imem_loader #(
  parameter int IMEM_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         error
);

  // One extra bit so the stored length can represent IMEM_WORDS itself.
  localparam int IDX_W = $clog2(IMEM_WORDS) + 1;

  typedef enum logic [1:0] {
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift_reg;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  len;
  logic              accept;
  logic              last_byte;
  logic              last_word;
  logic [31:0]       word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LEN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    bus.in_ready = 1'b0;
    accept       = 1'b0;
    last_byte    = 1'b0;
    last_word    = 1'b0;
    word         = {bus.in_data, shift_reg};

    case (state)
      S_LEN: begin
        busy         = 1'b1;
        bus.in_ready = !rst;
        accept       = bus.in_valid && !rst;
        last_byte    = accept && (byte_cnt == 2'd3);
        if (last_byte) begin
          if (word == 32'd0) begin
            state_next = S_DONE;
          end else if (word > 32'(IMEM_WORDS)) begin
            state_next = S_ERR;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        busy         = 1'b1;
        bus.in_ready = !rst;
        accept       = bus.in_valid && !rst;
        last_byte    = accept && (byte_cnt == 2'd3);
        last_word    = (word_idx == len - IDX_W'(1));
        if (last_byte && last_word) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = S_LEN;
        end
      end
      S_ERR: begin
        error = 1'b1;
        if (start) begin
          state_next = S_LEN;
        end
      end
      default: state_next = S_LEN;
    endcase
  end

  // Byte assembly, write port and CPU reset release; lanes 0..2 are staged, lane 3 completes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt         <= 2'd0;
      shift_reg        <= 24'd0;
      word_idx         <= '0;
      len              <= '0;
      bus.imem_wr_en   <= 1'b0;
      bus.imem_wr_addr <= 32'd0;
      bus.imem_wr_data <= 32'd0;
      cpu_rst_n        <= 1'b0;
    end else begin
      bus.imem_wr_en <= 1'b0;
      cpu_rst_n      <= (state == S_DONE) && !start;

      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    shift_reg[7:0]   <= bus.in_data;
          2'd1:    shift_reg[15:8]  <= bus.in_data;
          2'd2:    shift_reg[23:16] <= bus.in_data;
          default: ;
        endcase
      end

      if (state == S_LEN && last_byte) begin
        len      <= word[IDX_W-1:0];
        word_idx <= '0;
      end

      if (state == S_DATA && last_byte) begin
        bus.imem_wr_en   <= 1'b1;
        bus.imem_wr_addr <= 32'(word_idx) << 2;
        bus.imem_wr_data <= word;
        if (!last_word) begin
          word_idx <= word_idx + IDX_W'(1);
        end
      end

      // A reload starts a fresh frame from the count field.
      if ((state == S_DONE || state == S_ERR) && start) begin
        byte_cnt <= 2'd0;
        word_idx <= '0;
        len      <= '0;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 256, meaning instruction-memory capacity in 32-bit words (power of two, 4..65536).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  8  boot byte stream data.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  loader can accept a byte; a byte transfers on a cycle with in_valid && in_ready.
REQ-007 start  input  1  single-cycle pulse that requests a reload.
REQ-008 imem_wr_en  output  1  single-cycle instruction-memory write strobe.
REQ-009 imem_wr_addr  output  32  byte address of the write, always a multiple of 4.
REQ-010 imem_wr_data  output  32  instruction word to write.
REQ-011 cpu_rst_n  output  1  active-low CPU core reset; 0 holds the core.
REQ-012 busy  output  1  1 in S_LEN and S_DATA.
REQ-013 done  output  1  1 in S_DONE.
REQ-014 error  output  1  1 in S_ERR.

Function
REQ-015 FSM states: S_LEN, S_DATA, S_DONE, S_ERR.
REQ-016 Frame format: 4-byte little-endian word count N, then N words, each 4 bytes little-endian (first byte = bits 7:0).
REQ-017 in_ready = 1 in S_LEN and S_DATA, 0 in S_DONE and S_ERR, and 0 while rst is high.
REQ-018 A 2-bit byte counter selects the byte lane; it wraps 3->0 on each completed word or count field.
REQ-019 In S_LEN, after the 4th byte: N==0 -> S_DONE; N>IMEM_WORDS -> S_ERR; otherwise -> S_DATA with word index cleared to 0.
REQ-020 In S_DATA, the edge accepting byte 3 of word k registers imem_wr_en=1, imem_wr_addr=4*k, and imem_wr_data={b3,b2,b1,b0}; all three are valid in the following cycle.
REQ-021 imem_wr_en is high for exactly 1 cycle per word; imem_wr_addr and imem_wr_data hold their last values when imem_wr_en is 0.
REQ-022 The same edge that writes word N-1 moves the FSM to S_DONE; otherwise it increments the word index.
REQ-023 cpu_rst_n is registered: it becomes 1 on the first edge at which the state is S_DONE, i.e. 1 cycle after the final write pulse, or 1 cycle after entering S_DONE when N==0.
REQ-024 cpu_rst_n is 0 in every state other than S_DONE.
REQ-025 start is ignored in S_LEN and S_DATA.
REQ-026 start in S_DONE or S_ERR -> S_LEN, clearing the byte counter, word index and length; cpu_rst_n is 0 from the next cycle.
REQ-027 Idle stream cycles (in_valid=0) do not advance any counter; partial words are retained indefinitely.
REQ-028 Word-index arithmetic is wide enough for IMEM_WORDS; imem_wr_addr upper bits are zero-extended.

Reset
REQ-029 While rst is high: state S_LEN, counters and length 0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, cpu_rst_n=0, done=0, error=0, busy=1, in_ready=0.
REQ-030 Asserting rst mid-frame discards the partial frame; loading restarts with the count field after rst is released.

Verification
REQ-031 Stream 02 00 00 00, 13 00 10 00, 93 00 20 00 -> writes at addr 0 with data 0x00100013 and at addr 4 with data 0x00200093, one cycle each; done=1; cpu_rst_n rises 1 cycle after the second write.
REQ-032 Count 00 00 00 00 -> no imem_wr_en pulse, S_DONE, cpu_rst_n=1 one cycle later.
REQ-033 Count IMEM_WORDS+1 (0x101 for the default) -> error=1, in_ready=0, no writes, cpu_rst_n stays 0; a start pulse then returns to busy=1 with in_ready=1.
REQ-034 Random in_valid gaps, including multi-cycle stalls mid-word -> written data and addresses identical to the gap-free case.
REQ-035 rst pulsed after 2 bytes of word 1 -> all outputs return to reset values; a fresh full frame then loads correctly from addr 0.
REQ-036 start pulsed during S_DATA -> ignored; start pulsed in S_DONE -> cpu_rst_n=0 the next cycle, and a reload frame overwrites from addr 0.
